machine_csr_rfile: RTL
======================

Name: machine_csr_rfile

Overview:
- Machine-mode CSR register file: the responder end of the pipeline↔CSR interface (csr modport).
- Receives swap/set/clr strobes, address and write data from the execute stage; returns read data and an invalid flag in the same cycle.
- Commits the write at the next clock edge.
- Maintains free-running 64-bit mcycle and minstret counters alongside the software-visible machine registers.

Parameters:
- HART_ID, 32'h0, value returned by mhartid (0xF14).
- MIMPID, 32'h0, value returned by mimpid (0xF13).
- MISA_VALUE, 32'h40000100, value returned by misa (0x301); RV32I.

Ports:
- CLK  input  1  single clock.
- nRST  input  1  reset; asynchronous, active-low.
- swap  input  1  CSRRW-class op strobe.
- set  input  1  CSRRS-class op strobe.
- clr  input  1  CSRRC-class op strobe.
- addr  input  12  CSR address (csr_addr_t).
- wdata  input  32  operand (rs1 value or zero-extended uimm).
- rdata  output  32  current (pre-write) value of addressed CSR.
- invalid_csr  output  1  illegal access flag.
- inst_retired  input  1  one pulse per retired instruction.

Behaviour:
- Op strobes are one-hot or all-zero; more than one high is a protocol violation and the bench asserts against it. With no strobe, no write occurs and invalid_csr=0.
- rdata is combinational from addr, with zero latency. Unimplemented addresses read 0.
- Write value, committed at the next rising CLK edge:
  - swap: new = wdata.
  - set: new = old | wdata.
  - clr: new = old & ~wdata.
- A write is effective when swap=1, or when set/clr=1 and wdata!=0.
- invalid_csr=1, combinational, when a strobe is active and either:
  - addr is unimplemented; or
  - addr[11:10]==2'b11 (read-only space) and the write is effective.
- When invalid_csr=1, no state changes.
- Implemented registers and WARL rules:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads 2'b11. All other bits read 0.
  - misa 0x301: writes are accepted and ignored (not invalid); reads MISA_VALUE.
  - mtvec 0x305: bits[31:2] writable. Mode bits[1:0] accept 00/01; a written 1x leaves mode unchanged.
  - mscratch 0x340: all 32 bits writable.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342: all 32 bits writable.
  - mtval 0x343: all 32 bits writable.
  - mcycle 0xB00 / mcycleh 0xB80: writable halves of the 64-bit cycle counter.
  - minstret 0xB02 / minstreth 0xB82: writable halves of the 64-bit instret counter.
  - cycle 0xC00 / cycleh 0xC80 / instret 0xC02 / instreth 0xC82: read-only aliases.
  - mvendorid 0xF11 and marchid 0xF12 read 0; mimpid 0xF13 reads MIMPID; mhartid 0xF14 reads HART_ID.
- Counters:
  - mcycle +1 every cycle out of reset.
  - minstret +1 on each cycle with inst_retired=1.
  - Both wrap from 2^64-1 to 0.
  - A software write to either half in the same cycle takes priority: that half takes the written value, the other half holds, and there is no increment that cycle.
  - The increment carries from low into high half.
- rdata of a counter reflects the pre-increment value in that cycle.
- Reset (asynchronous, nRST low), mid-operation included:
  - All writable registers and counters clear to 0; mtvec = 0.
  - A pending write is discarded.
  - rdata follows addr combinationally even during reset, reading the reset values.

Decomposition:
- machine_mode_types_pkg holds:
  - all CSR address constants as csr_addr_t values;
  - mstatus_t packed struct (MIE/MPIE/MPP fields);
  - mtvec mode enum (DIRECT=2'b00, VECTORED=2'b01);
  - constant MPP_MACHINE=2'b11.
- word_t comes from rv32i_types_pkg.
- One sub-module, csr_counter64, instantiated twice (mcycle, minstret). Ports: CLK, nRST, inc, wr_lo, wr_hi, wdata[31:0], count[63:0]; it implements the write-priority and carry rules.

Test Plan:
- Reset, then 10 idle cycles: read 0xB00 → rdata=10±0 relative to first post-reset edge; read 0xC00 gives the identical value; 0xB80 → 0.
- swap addr=0x340, wdata=32'hDEADBEEF: rdata=0 in that cycle. Next cycle set addr=0x340, wdata=0x10 → rdata=DEADBEEF. Following cycle clr addr=0x340, wdata=32'hFFFF0000 → rdata=DEADBEFF; final value 0x0000BEFF.
- swap 0xC00 wdata=5 → invalid_csr=1 and mcycle unaffected. set 0xC00 wdata=0 → invalid_csr=0 and rdata=cycle. Any strobe with addr 0x7C0 → invalid_csr=1, rdata=0.
- swap 0xB00 wdata=32'hFFFFFFFF, swap 0xB80 wdata=32'hFFFFFFFF on consecutive cycles; then one idle cycle → counter wraps to 0. Next cycle reads 0xB00=1, 0xB80=0.
- WARL:
  - swap 0x300 wdata=32'hFFFFFFFF → mstatus reads 0x00001888.
  - swap 0x341 wdata=0x1003 → mepc reads 0x1000.
  - swap 0x305 wdata=0x102 → mtvec reads 0x100.
  - swap 0x301 wdata=0 → invalid_csr=0 and misa still reads 0x40000100.
- inst_retired high 7 of 12 cycles → minstret=7. A swap 0xB02 wdata=100 in a cycle with inst_retired=1 → reads 100 next cycle. nRST asserted mid-stream → all counters 0 immediately.

Source files
------------

// File: rtl/machine_mode_types_pkg.sv
// Machine-mode CSR addresses, mstatus layout and mtvec mode encoding.
package machine_mode_types_pkg;
  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t MSTATUS_ADDR   = 12'h300;
  localparam csr_addr_t MISA_ADDR      = 12'h301;
  localparam csr_addr_t MTVEC_ADDR     = 12'h305;
  localparam csr_addr_t MSCRATCH_ADDR  = 12'h340;
  localparam csr_addr_t MEPC_ADDR      = 12'h341;
  localparam csr_addr_t MCAUSE_ADDR    = 12'h342;
  localparam csr_addr_t MTVAL_ADDR     = 12'h343;
  localparam csr_addr_t MCYCLE_ADDR    = 12'hB00;
  localparam csr_addr_t MINSTRET_ADDR  = 12'hB02;
  localparam csr_addr_t MCYCLEH_ADDR   = 12'hB80;
  localparam csr_addr_t MINSTRETH_ADDR = 12'hB82;
  localparam csr_addr_t CYCLE_ADDR     = 12'hC00;
  localparam csr_addr_t INSTRET_ADDR   = 12'hC02;
  localparam csr_addr_t CYCLEH_ADDR    = 12'hC80;
  localparam csr_addr_t INSTRETH_ADDR  = 12'hC82;
  localparam csr_addr_t MVENDORID_ADDR = 12'hF11;
  localparam csr_addr_t MARCHID_ADDR   = 12'hF12;
  localparam csr_addr_t MIMPID_ADDR    = 12'hF13;
  localparam csr_addr_t MHARTID_ADDR   = 12'hF14;

  localparam logic [1:0] MPP_MACHINE = 2'b11;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef struct packed {
    logic [18:0] rsvd_31_13;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_10_8;
    logic        mpie;
    logic [2:0]  rsvd_6_4;
    logic        mie;
    logic [2:0]  rsvd_2_0;
  } mstatus_t;

  typedef enum logic [1:0] {
    DIRECT   = 2'b00,
    VECTORED = 2'b01
  } mtvec_mode_t;
endpackage

// File: rtl/rv32i_types_pkg.sv
// Base RV32I scalar types shared across the pipeline and CSR file.
package rv32i_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half software write that overrides the increment.
module csr_counter64
  import rv32i_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  word_t       wdata,
  output logic [63:0] count
);
  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo)       count_d[31:0]  = wdata;
    else if (wr_hi)  count_d[63:32] = wdata;
    else if (inc)    count_d        = count_q + 64'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/machine_csr_rfile.sv
// Machine-mode CSR register file: same-cycle read/invalid response, write committed on the next edge.
module machine_csr_rfile
  import rv32i_types_pkg::*;
  import machine_mode_types_pkg::*;
#(
  parameter word_t HART_ID    = 32'h0,
  parameter word_t MIMPID     = 32'h0,
  parameter word_t MISA_VALUE = 32'h4000_0100
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      swap,
  input  logic      set,
  input  logic      clr,
  input  csr_addr_t addr,
  input  word_t     wdata,
  output word_t     rdata,
  output logic      invalid_csr,
  input  logic      inst_retired
);
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [29:0] mtvec_base_q, mtvec_base_d;
  mtvec_mode_t mtvec_mode_q, mtvec_mode_d;
  word_t       mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;
  word_t       mcause_q, mcause_d;
  word_t       mtval_q, mtval_d;
  logic [63:0] mcycle, minstret;

  logic     strobe, effective, implemented, we;
  word_t    rd_val, wr_val;
  mstatus_t mstatus_rd;

  always_comb begin
    mstatus_rd      = '0;
    mstatus_rd.mie  = mie_q;
    mstatus_rd.mpie = mpie_q;
    mstatus_rd.mpp  = MPP_MACHINE;
  end

  always_comb begin
    rd_val      = '0;
    implemented = 1'b1;
    case (addr)
      MSTATUS_ADDR:                   rd_val = mstatus_rd;
      MISA_ADDR:                      rd_val = MISA_VALUE;
      MTVEC_ADDR:                     rd_val = {mtvec_base_q, mtvec_mode_q};
      MSCRATCH_ADDR:                  rd_val = mscratch_q;
      MEPC_ADDR:                      rd_val = {mepc_q, 2'b00};
      MCAUSE_ADDR:                    rd_val = mcause_q;
      MTVAL_ADDR:                     rd_val = mtval_q;
      MCYCLE_ADDR,    CYCLE_ADDR:     rd_val = mcycle[31:0];
      MCYCLEH_ADDR,   CYCLEH_ADDR:    rd_val = mcycle[63:32];
      MINSTRET_ADDR,  INSTRET_ADDR:   rd_val = minstret[31:0];
      MINSTRETH_ADDR, INSTRETH_ADDR:  rd_val = minstret[63:32];
      MVENDORID_ADDR, MARCHID_ADDR:   rd_val = '0;
      MIMPID_ADDR:                    rd_val = MIMPID;
      MHARTID_ADDR:                   rd_val = HART_ID;
      default:                        implemented = 1'b0;
    endcase
  end

  // set/clr with a zero operand is a pure read, so it is legal on read-only CSRs.
  assign strobe      = swap | set | clr;
  assign effective   = swap | ((set | clr) & (wdata != '0));
  assign invalid_csr = strobe & (~implemented | ((addr[11:10] == 2'b11) & effective));
  assign we          = strobe & effective & ~invalid_csr;
  assign rdata       = rd_val;

  always_comb begin
    wr_val = rd_val;
    if (swap)     wr_val = wdata;
    else if (set) wr_val = rd_val | wdata;
    else if (clr) wr_val = rd_val & ~wdata;
  end

  always_comb begin
    mie_d        = mie_q;
    mpie_d       = mpie_q;
    mtvec_base_d = mtvec_base_q;
    mtvec_mode_d = mtvec_mode_q;
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    if (we) begin
      case (addr)
        MSTATUS_ADDR: begin
          mie_d  = wr_val[MSTATUS_MIE_BIT];
          mpie_d = wr_val[MSTATUS_MPIE_BIT];
        end
        MTVEC_ADDR: begin
          mtvec_base_d = wr_val[31:2];
          if (!wr_val[1]) mtvec_mode_d = wr_val[0] ? VECTORED : DIRECT;
        end
        MSCRATCH_ADDR: mscratch_d = wr_val;
        MEPC_ADDR:     mepc_d     = wr_val[31:2];
        MCAUSE_ADDR:   mcause_d   = wr_val;
        MTVAL_ADDR:    mtval_d    = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      mtvec_base_q <= '0;
      mtvec_mode_q <= DIRECT;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      mie_q        <= mie_d;
      mpie_q       <= mpie_d;
      mtvec_base_q <= mtvec_base_d;
      mtvec_mode_q <= mtvec_mode_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (1'b1),
    .wr_lo (we && (addr == MCYCLE_ADDR)),
    .wr_hi (we && (addr == MCYCLEH_ADDR)),
    .wdata (wr_val),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (inst_retired),
    .wr_lo (we && (addr == MINSTRET_ADDR)),
    .wr_hi (we && (addr == MINSTRETH_ADDR)),
    .wdata (wr_val),
    .count (minstret)
  );
endmodule
